// File: rtl/ed_window_ctrl_if.sv
// Pixel/class stream bundle for ed_window_ctrl: input stream, classifier taps and result,
// output class stream. The slave modport is the controller side.
interface ed_window_ctrl_if;
    logic            s_valid;
    logic            s_ready;
    logic [7:0]      s_pixel;
    logic [8:0][7:0] win;
    logic [1:0]      cls_in;
    logic            m_valid;
    logic            m_ready;
    logic [1:0]      m_class;
    logic            m_last;

    modport master (
        output s_valid, s_pixel, cls_in, m_ready,
        input  s_ready, win, m_valid, m_class, m_last
    );

    modport slave (
        input  s_valid, s_pixel, cls_in, m_ready,
        output s_ready, win, m_valid, m_class, m_last
    );
endinterface

// File: rtl/ed_window_ctrl.sv
// Raster-scan 3x3 window sequencer: two line buffers feed a window register presented to an
// external edge classifier; the registered class is streamed out with framing and a count.
module ed_window_ctrl #(
    parameter int unsigned IMG_WIDTH  = 320,
    parameter int unsigned IMG_HEIGHT = 240
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    ed_window_ctrl_if.slave    bus,
    output logic [31:0]        o_edge_cnt,
    output logic               o_busy,
    output logic               o_done
);
    localparam int unsigned ColW = $clog2(IMG_WIDTH);
    localparam int unsigned RowW = $clog2(IMG_HEIGHT);
    localparam logic [ColW-1:0] ColLast = ColW'(IMG_WIDTH - 1);
    localparam logic [RowW-1:0] RowLast = RowW'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e          r_state;
    state_e          w_state_next;
    logic [ColW-1:0] r_col;
    logic [RowW-1:0] r_row;
    logic [7:0]      r_lb1 [IMG_WIDTH];
    logic [7:0]      r_lb2 [IMG_WIDTH];
    logic [8:0][7:0] r_win;
    logic            r_wv;
    logic            r_wlast;
    logic            r_m_valid;
    logic [1:0]      r_m_class;
    logic            r_m_last;
    logic [31:0]     r_edge_cnt;
    logic            r_done;

    logic            w_advance;
    logic            w_accept;
    logic            w_last_pix;
    logic            w_start_ok;
    logic            w_out_hs;

    // The whole pipeline moves only when the output register can take a new value.
    assign w_advance  = !r_m_valid || bus.m_ready;
    assign bus.s_ready = (r_state == StRun) && w_advance;
    assign w_accept   = bus.s_valid && bus.s_ready;
    assign w_last_pix = (r_row == RowLast) && (r_col == ColLast);
    assign w_start_ok = i_start && (r_state == StIdle);
    assign w_out_hs   = r_m_valid && bus.m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_next = StRun;
                end
            end
            StRun: begin
                if (w_accept && w_last_pix) begin
                    w_state_next = StDrain;
                end
            end
            StDrain: begin
                if (w_out_hs && r_m_last) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Line buffers are deliberately not reset; the wv gating never uses stale rows.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb2[r_col] <= r_lb1[r_col];
            r_lb1[r_col] <= bus.s_pixel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col      <= '0;
            r_row      <= '0;
            r_win      <= '0;
            r_wv       <= 1'b0;
            r_wlast    <= 1'b0;
            r_m_valid  <= 1'b0;
            r_m_class  <= 2'b00;
            r_m_last   <= 1'b0;
            r_edge_cnt <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= (r_state == StDrain) && w_out_hs && r_m_last;
            if (w_start_ok) begin
                r_col      <= '0;
                r_row      <= '0;
                r_wv       <= 1'b0;
                r_wlast    <= 1'b0;
                r_m_valid  <= 1'b0;
                r_m_last   <= 1'b0;
                r_edge_cnt <= '0;
            end else begin
                if (w_out_hs && (r_m_class != 2'b00)) begin
                    r_edge_cnt <= r_edge_cnt + 32'd1;
                end
                if (w_accept) begin
                    if (r_col == ColLast) begin
                        r_col <= '0;
                        r_row <= (r_row == RowLast) ? '0 : r_row + RowW'(1);
                    end else begin
                        r_col <= r_col + ColW'(1);
                    end
                end
                if (w_advance) begin
                    if (w_accept) begin
                        r_win[0] <= r_win[1];
                        r_win[1] <= r_win[2];
                        r_win[2] <= r_lb2[r_col];
                        r_win[3] <= r_win[4];
                        r_win[4] <= r_win[5];
                        r_win[5] <= r_lb1[r_col];
                        r_win[6] <= r_win[7];
                        r_win[7] <= r_win[8];
                        r_win[8] <= bus.s_pixel;
                        // Border and row-wrap windows are never marked valid.
                        r_wv    <= (r_row >= RowW'(2)) && (r_col >= ColW'(2));
                        r_wlast <= w_last_pix;
                    end else begin
                        r_wv    <= 1'b0;
                        r_wlast <= 1'b0;
                    end
                    r_m_class <= bus.cls_in;
                    r_m_valid <= r_wv;
                    r_m_last  <= r_wv && r_wlast;
                end
            end
        end
    end

    assign bus.win     = r_win;
    assign bus.m_valid = r_m_valid;
    assign bus.m_class = r_m_class;
    assign bus.m_last  = r_m_last;
    assign o_edge_cnt  = r_edge_cnt;
    assign o_busy      = (r_state != StIdle);
    assign o_done      = r_done;
endmodule

// File: tb/tb_ed_window_ctrl.sv
// Directed bench for ed_window_ctrl on a 5x4 frame with a behavioural classifier stub.
module tb_ed_window_ctrl;
    localparam int W = 5;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] edge_cnt;
    logic        busy;
    logic        done;
    int          cls_mode;
    int          n_checks = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    int          exp_tab [6] = '{1, 2, 3, 1, 2, 3};

    ed_window_ctrl_if bus();

    ed_window_ctrl #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (start),
        .bus        (bus),
        .o_edge_cnt (edge_cnt),
        .o_busy     (busy),
        .o_done     (done)
    );

    always #5 clk = ~clk;

    always_comb begin
        bus.cls_in = 2'b00;
        if (cls_mode == 1) bus.cls_in = bus.win[4][1:0];
        else if (cls_mode == 2) bus.cls_in = 2'b10;
    end

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pix(input int pmode, input int idx);
        return (pmode == 1) ? 8'(16 * (idx / W) + (idx % W)) : 8'd100;
    endfunction

    task automatic chk_reset(input string pfx);
        chk({pfx, "_s_ready"}, bus.s_ready, 0);
        chk({pfx, "_m_valid"}, bus.m_valid, 0);
        chk({pfx, "_m_last"}, bus.m_last, 0);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_done"}, done, 0);
        chk({pfx, "_m_class"}, bus.m_class, 0);
        chk({pfx, "_edge_cnt"}, edge_cnt, 0);
        chk({pfx, "_win"}, bus.win, 0);
    endtask

    task automatic run_frame(input int pmode, input int cmode, input bit gaps, input bit stall,
                             input bit start_mid, input bit chk_lat, input bit chk_taps,
                             input int exp_edges);
        int idx = 0;
        int n_out = 0;
        int hs_cyc = -1;
        int done_cyc = -1;
        int n_done = 0;
        int acc12_cyc = -1;
        int first_mv = -1;
        bit have_saved = 1'b0;
        bit taps_due = 1'b0;
        logic [8:0][7:0] saved;
        logic [1:0] ec;
        cls_mode = cmode;
        @(posedge clk); #1;
        start = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_pixel = pix(pmode, 0);
        bus.m_ready = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (taps_due) begin
                chk("first_taps", bus.win, {8'd34, 8'd33, 8'd32, 8'd18, 8'd17, 8'd16,
                                            8'd2, 8'd1, 8'd0});
                taps_due = 1'b0;
            end
            if (have_saved) chk("stall_taps", bus.win, saved);
            have_saved = 1'b0;
            if (bus.m_valid && !bus.m_ready) begin
                chk("stall_s_ready", bus.s_ready, 0);
                saved = bus.win;
                have_saved = 1'b1;
            end
            if (bus.m_valid && first_mv < 0) first_mv = cyc;
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (bus.m_valid && bus.m_ready) begin
                if (cmode == 0) ec = 2'd0;
                else if (cmode == 2) ec = 2'd2;
                else ec = (n_out < 6) ? 2'(exp_tab[n_out]) : 2'd0;
                chk("class", bus.m_class, ec);
                chk("last", bus.m_last, (n_out == 5));
                if (bus.m_last) hs_cyc = cyc;
                n_out++;
            end
            if (bus.s_valid && bus.s_ready) begin
                if (idx == 12) begin
                    acc12_cyc = cyc;
                    taps_due = chk_taps;
                end
                idx++;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                chk("done_pulse", done, 0);
                break;
            end
            @(posedge clk); #1;
            start = start_mid && (cyc == 6);
            bus.s_valid = (idx < W * H) && (gaps ? ($urandom_range(0, 1) == 1) : 1'b1);
            bus.s_pixel = bus.s_valid ? pix(pmode, idx) : 8'($urandom);
            if (stall) bus.m_ready = ~bus.m_ready;
        end
        start = 1'b0;
        chk("n_out", n_out, 6);
        chk("n_done", n_done, 1);
        chk("done_timing", done_cyc, hs_cyc + 1);
        chk("edge_cnt", edge_cnt, exp_edges);
        chk("busy_after", busy, 0);
        if (chk_lat) chk("latency", first_mv - acc12_cyc, 2);
    endtask

    initial begin
        int idx;
        rst = 1'b1;
        start = 1'b0;
        cls_mode = 0;
        bus.s_valid = 1'b0;
        bus.s_pixel = 8'd0;
        bus.m_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset("por");
        @(posedge clk); #1;
        rst = 1'b0;

        // Uniform frame, classifier always 0.
        run_frame(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        // Ramp frame, class = centre[1:0].
        run_frame(1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6);
        // Constant class 2 with m_ready toggling.
        run_frame(1, 2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6);
        // Random input gaps.
        run_frame(1, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6);
        repeat (3) @(negedge clk);
        chk("edge_hold", edge_cnt, 6);

        // Reset after nine pixels of a frame.
        cls_mode = 2;
        idx = 0;
        @(posedge clk); #1;
        start = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_pixel = pix(1, 0);
        bus.m_ready = 1'b1;
        for (int cyc = 0; cyc < 50; cyc++) begin
            @(negedge clk);
            if (bus.s_valid && bus.s_ready) idx++;
            if (idx == 9) break;
            @(posedge clk); #1;
            start = 1'b0;
            bus.s_pixel = pix(1, idx);
        end
        chk("pre_rst_pixels", idx, 9);
        @(posedge clk); #1;
        start = 1'b0;
        rst = 1'b1;
        bus.s_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_class", bus.m_class, 2);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_reset("mid_rst");
        run_frame(1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6);

        // start pulsed during RUN must be ignored.
        run_frame(1, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
